// File: rtl/ltl_seq_pkg.sv
// Shared types for the LTL automaton sequencer: FSM states, report FIFO entry and
// backpressure threshold.
package ltl_seq_pkg;

  typedef enum logic [1:0] {IDLE, FLUSH, STREAM, DRAIN} seq_state_t;

  localparam int unsigned RPT_VEC_W    = 4;
  localparam int unsigned RPT_OFF_W    = 16;
  // Free FIFO entries needed to accept a beat: the beat itself plus two in-flight captures.
  localparam int unsigned RPT_FREE_MIN = 3;

  typedef struct packed {
    logic [RPT_VEC_W-1:0] vec;
    logic [RPT_OFF_W-1:0] offset;
  } rpt_entry_t;

endpackage

// File: rtl/ltl_automata_sequencer_if.sv
// Trace input, automaton drive and report output bundle of the sequencer.
// master = sequencer side, slave = front end / automaton / collector side.
interface ltl_automata_sequencer_if #(
  parameter int unsigned NUM_REPORTS = 4,
  parameter int unsigned OFFSET_W    = 16
) ();
  logic                   start;
  logic                   busy;
  logic                   done;
  logic                   in_valid;
  logic                   in_ready;
  logic [7:0]             in_data;
  logic                   in_last;
  logic                   am_reset;
  logic                   am_run;
  logic [7:0]             am_symbols;
  logic [NUM_REPORTS-1:0] am_reports;
  logic                   rpt_valid;
  logic                   rpt_ready;
  logic [NUM_REPORTS-1:0] rpt_vec;
  logic [OFFSET_W-1:0]    rpt_offset;

  modport master (
    input  start, in_valid, in_data, in_last, am_reports, rpt_ready,
    output busy, done, in_ready, am_reset, am_run, am_symbols, rpt_valid, rpt_vec, rpt_offset
  );

  modport slave (
    output start, in_valid, in_data, in_last, am_reports, rpt_ready,
    input  busy, done, in_ready, am_reset, am_run, am_symbols, rpt_valid, rpt_vec, rpt_offset
  );
endinterface

// File: rtl/ltl_report_fifo.sv
// First-word-fall-through FIFO for tagged report entries with occupancy output.
// Push and pop together on a full FIFO are both honoured.
module ltl_report_fifo
  import ltl_seq_pkg::*;
#(
  parameter int unsigned Depth = 4,
  parameter type entry_t = rpt_entry_t
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    i_push,
  input  entry_t                  i_data,
  input  logic                    i_pop,
  output entry_t                  o_data,
  output logic                    o_empty,
  output logic [$clog2(Depth):0]  o_count
);
  localparam int unsigned AW = $clog2(Depth);

  entry_t         r_mem [Depth];
  logic [AW-1:0]  r_wr_ptr;
  logic [AW-1:0]  r_rd_ptr;
  logic [AW:0]    r_count;
  logic           w_full;
  logic           w_do_push;
  logic           w_do_pop;

  assign o_empty   = (r_count == '0);
  assign w_full    = (r_count == (AW+1)'(Depth));
  assign w_do_pop  = i_pop && !o_empty;
  assign w_do_push = i_push && (!w_full || w_do_pop);
  assign o_data    = r_mem[r_rd_ptr];
  assign o_count   = r_count;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_do_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_do_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      if (w_do_push && !w_do_pop)      r_count <= r_count + 1'b1;
      else if (!w_do_push && w_do_pop) r_count <= r_count - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (w_do_push) r_mem[r_wr_ptr] <= i_data;
  end

endmodule

// File: rtl/ltl_automata_sequencer.sv
// Sequences one LTL monitor automaton over a byte trace and queues nonzero report
// vectors tagged with the offset of the symbol that produced them.
module ltl_automata_sequencer
  import ltl_seq_pkg::*;
#(
  parameter int unsigned NUM_REPORTS  = 4,
  parameter int unsigned OFFSET_W     = 16,
  parameter int unsigned FIFO_DEPTH   = 4,
  parameter int unsigned RESET_CYCLES = 2
) (
  input logic                      clk,
  input logic                      reset,
  ltl_automata_sequencer_if.master bus
);
  localparam int unsigned FlushW = (RESET_CYCLES < 1) ? 1 : $clog2(RESET_CYCLES + 1);
  localparam int unsigned CountW = $clog2(FIFO_DEPTH) + 1;

  typedef struct packed {
    logic [NUM_REPORTS-1:0] vec;
    logic [OFFSET_W-1:0]    offset;
  } entry_t;

  seq_state_t          r_state;
  seq_state_t          w_state_d;
  logic [OFFSET_W-1:0] r_offset;
  logic [FlushW-1:0]   r_flush_cnt;
  logic                r_am_reset;
  logic                r_am_run;
  logic [7:0]          r_am_symbols;
  logic [OFFSET_W-1:0] r_off_s1;
  logic                r_v2;
  logic [OFFSET_W-1:0] r_off_s2;

  logic                w_flush_full;
  logic                w_room;
  logic                w_in_ready;
  logic                w_accept;
  logic                w_done;
  logic                w_push;
  logic                w_pop;
  logic                w_fifo_empty;
  logic [CountW-1:0]   w_fifo_count;
  entry_t              w_push_entry;
  entry_t              w_head;

  assign w_flush_full = (r_flush_cnt == FlushW'(RESET_CYCLES));
  assign w_room       = (int'(w_fifo_count) + int'(RPT_FREE_MIN)) <= int'(FIFO_DEPTH);

  always_comb begin
    w_state_d  = r_state;
    w_in_ready = 1'b0;
    w_accept   = 1'b0;
    w_done     = 1'b0;
    unique case (r_state)
      IDLE: begin
        if (bus.start) w_state_d = FLUSH;
      end
      FLUSH: begin
        w_in_ready = w_flush_full && w_room;
        w_accept   = w_in_ready && bus.in_valid;
        if (w_accept) w_state_d = bus.in_last ? DRAIN : STREAM;
      end
      STREAM: begin
        w_in_ready = w_room;
        w_accept   = w_in_ready && bus.in_valid;
        if (w_accept && bus.in_last) w_state_d = DRAIN;
      end
      DRAIN: begin
        // Both capture stages and the FIFO must be empty before the trace is complete.
        if (!r_am_run && !r_v2 && w_fifo_empty) begin
          w_done    = 1'b1;
          w_state_d = IDLE;
        end
      end
      default: w_state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state      <= IDLE;
      r_offset     <= '0;
      r_flush_cnt  <= '0;
      r_am_reset   <= 1'b1;
      r_am_run     <= 1'b0;
      r_am_symbols <= '0;
      r_off_s1     <= '0;
      r_v2         <= 1'b0;
      r_off_s2     <= '0;
    end else begin
      r_state  <= w_state_d;
      r_am_run <= w_accept;
      r_v2     <= r_am_run;
      r_off_s2 <= r_off_s1;
      if (w_accept) begin
        r_am_symbols <= bus.in_data;
        r_off_s1     <= r_offset;
        r_offset     <= r_offset + 1'b1;
        r_am_reset   <= 1'b0;
      end
      if (r_state == IDLE && bus.start) begin
        r_offset    <= '0;
        r_flush_cnt <= '0;
      end else if (r_state == FLUSH && !w_flush_full) begin
        r_flush_cnt <= r_flush_cnt + 1'b1;
      end
      if (w_done) r_am_reset <= 1'b1;
    end
  end

  assign w_push       = r_v2 && (bus.am_reports != '0);
  assign w_push_entry = '{vec: bus.am_reports, offset: r_off_s2};
  assign w_pop        = !w_fifo_empty && bus.rpt_ready;

  ltl_report_fifo #(
    .Depth   (FIFO_DEPTH),
    .entry_t (entry_t)
  ) u_fifo (
    .clk     (clk),
    .reset   (reset),
    .i_push  (w_push),
    .i_data  (w_push_entry),
    .i_pop   (w_pop),
    .o_data  (w_head),
    .o_empty (w_fifo_empty),
    .o_count (w_fifo_count)
  );

  assign bus.busy       = (r_state != IDLE);
  assign bus.done       = w_done;
  assign bus.in_ready   = w_in_ready;
  assign bus.am_reset   = r_am_reset;
  assign bus.am_run     = r_am_run;
  assign bus.am_symbols = r_am_symbols;
  assign bus.rpt_valid  = !w_fifo_empty;
  assign bus.rpt_vec    = w_head.vec;
  assign bus.rpt_offset = w_head.offset;

endmodule

// File: tb/tb_ltl_automata_sequencer.sv
// Bench for ltl_automata_sequencer: a behavioural automaton feeds reports back, and a
// scoreboard queues expected {vec, offset} entries at each accepted beat.
module tb_ltl_automata_sequencer;
  localparam int unsigned NR = 4;
  localparam int unsigned OW = 4;
  localparam int unsigned FD = 4;
  localparam int unsigned RC = 2;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  ltl_automata_sequencer_if #(.NUM_REPORTS(NR), .OFFSET_W(OW)) bus ();

  ltl_automata_sequencer #(
    .NUM_REPORTS  (NR),
    .OFFSET_W     (OW),
    .FIFO_DEPTH   (FD),
    .RESET_CYCLES (RC)
  ) u_dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int n_checks = 0;
  int n_errors = 0;
  int mode = 0;
  int done_cnt = 0;
  int acc_cnt = 0;
  int pop_cnt = 0;
  logic [NR+OW-1:0] sb_q[$];
  logic [7:0] trace_q[$];
  logic exp_run_next = 1'b0;
  logic [7:0] exp_sym = '0;
  logic [OW-1:0] exp_off = '0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [NR-1:0] rpt_fn(input int m, input logic [7:0] d);
    case (m)
      1:       return d[3:0];
      2:       return {d[7:5], 1'b1};
      default: return '0;
    endcase
  endfunction

  // Automaton model: registered report states, one step per am_run.
  always @(posedge clk) begin
    if (reset || bus.am_reset) bus.am_reports <= '0;
    else if (bus.am_run)      bus.am_reports <= rpt_fn(mode, bus.am_symbols);
  end

  always @(negedge clk) begin
    logic [NR+OW-1:0] exp_e;
    logic [NR-1:0]    v;
    if (reset) begin
      sb_q.delete();
      exp_run_next = 1'b0;
      exp_off      = '0;
    end else begin
      check_eq("am_run", bus.am_run, exp_run_next);
      if (exp_run_next) check_eq("am_symbols", bus.am_symbols, exp_sym);
      if (bus.done) done_cnt++;
      if (bus.start && !bus.busy) exp_off = '0;
      if (bus.rpt_valid && bus.rpt_ready) begin
        exp_e = (sb_q.size() > 0) ? sb_q.pop_front() : '0;
        check_eq("rpt_entry", {bus.rpt_vec, bus.rpt_offset}, exp_e);
        pop_cnt++;
      end
      exp_run_next = bus.in_valid && bus.in_ready;
      if (exp_run_next) begin
        exp_sym = bus.in_data;
        acc_cnt++;
        v = rpt_fn(mode, bus.in_data);
        if (v != '0) sb_q.push_back({v, exp_off});
        exp_off++;
      end
    end
  end

  task automatic check_reset_state();
    check_eq("rst_busy", bus.busy, 0);
    check_eq("rst_done", bus.done, 0);
    check_eq("rst_in_ready", bus.in_ready, 0);
    check_eq("rst_am_reset", bus.am_reset, 1);
    check_eq("rst_am_run", bus.am_run, 0);
    check_eq("rst_am_symbols", bus.am_symbols, 0);
    check_eq("rst_rpt_valid", bus.rpt_valid, 0);
  endtask

  task automatic apply_reset(input int cycles);
    reset = 1'b1;
    bus.start = 1'b0;
    bus.in_valid = 1'b0;
    bus.in_last = 1'b0;
    repeat (cycles) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    check_reset_state();
    @(posedge clk);
    #1;
  endtask

  task automatic start_trace();
    int n = 0;
    bus.start = 1'b1;
    @(posedge clk);
    #1 bus.start = 1'b0;
    do begin
      @(negedge clk);
      n++;
    end while (!bus.in_ready && n < 50);
    check_eq("start_ready", bus.in_ready, 1);
    @(posedge clk);
    #1;
  endtask

  task automatic send_beat(input logic [7:0] d, input logic last);
    int n = 0;
    bus.in_valid = 1'b1;
    bus.in_data = d;
    bus.in_last = last;
    forever begin
      @(negedge clk);
      if (bus.in_ready) break;
      n++;
      if (n > 500) begin
        check_eq("beat_accept", bus.in_ready, 1);
        break;
      end
    end
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    bus.in_last = 1'b0;
  endtask

  task automatic send_trace();
    for (int i = 0; i < trace_q.size(); i++) send_beat(trace_q[i], i == trace_q.size() - 1);
  endtask

  task automatic wait_done(input int budget);
    int n = 0;
    logic seen = 1'b0;
    while (n < budget && !seen) begin
      @(negedge clk);
      n++;
      if (bus.done) seen = 1'b1;
    end
    check_eq("done_seen", seen, 1);
    check_eq("done_latency_ge3", n >= 3, 1);
    @(posedge clk);
    #1;
    check_eq("idle_busy", bus.busy, 0);
    check_eq("idle_am_reset", bus.am_reset, 1);
    check_eq("sb_drained", sb_q.size(), 0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int base;
    bus.rpt_ready = 1'b1;
    bus.in_data = '0;
    apply_reset(2);

    // Start timing, then three back-to-back symbols with no reports.
    mode = 0;
    bus.start = 1'b1;
    @(posedge clk);
    #1 bus.start = 1'b0;
    @(negedge clk);
    check_eq("flush_busy", bus.busy, 1);
    check_eq("flush_am_reset", bus.am_reset, 1);
    check_eq("flush_ready0", bus.in_ready, 0);
    @(negedge clk);
    check_eq("flush_ready1", bus.in_ready, 0);
    @(negedge clk);
    check_eq("flush_ready2", bus.in_ready, 1);
    @(posedge clk);
    #1;
    trace_q = '{8'h10, 8'h50, 8'hC8};
    send_trace();
    wait_done(50);

    // Single-symbol trace with a report.
    mode = 2;
    start_trace();
    send_beat(8'hA7, 1'b1);
    wait_done(50);

    // Only offset 5 reports.
    mode = 1;
    base = pop_cnt;
    start_trace();
    trace_q = '{8'h30, 8'h40, 8'h50, 8'h60, 8'h70, 8'h04, 8'h80, 8'h90};
    send_trace();
    wait_done(50);
    check_eq("single_entry", pop_cnt - base, 1);

    // Backpressure: collector stalled, every symbol reports.
    mode = 2;
    bus.rpt_ready = 1'b0;
    start_trace();
    base = acc_cnt;
    fork
      begin
        for (int i = 0; i < 6; i++) send_beat(8'(8'h21 * (i + 1)), i == 5);
      end
      begin
        repeat (12) @(negedge clk);
        check_eq("bp_in_ready", bus.in_ready, 0);
        check_eq("bp_rpt_valid", bus.rpt_valid, 1);
        check_eq("bp_accepted", acc_cnt - base, 4);
        @(posedge clk);
        #1 bus.rpt_ready = 1'b1;
      end
    join
    wait_done(100);

    // 18 symbols through a 4-bit offset: tags wrap 15 -> 0 -> 1.
    mode = 2;
    base = pop_cnt;
    start_trace();
    trace_q.delete();
    for (int i = 0; i < 18; i++) trace_q.push_back(8'(i * 13 + 1));
    send_trace();
    wait_done(100);
    check_eq("wrap_entries", pop_cnt - base, 18);

    // start during STREAM is ignored; offsets continue.
    mode = 2;
    start_trace();
    send_beat(8'h11, 1'b0);
    send_beat(8'h22, 1'b0);
    send_beat(8'h33, 1'b0);
    bus.start = 1'b1;
    @(posedge clk);
    #1 bus.start = 1'b0;
    @(negedge clk);
    check_eq("ign_busy", bus.busy, 1);
    check_eq("ign_in_ready", bus.in_ready, 1);
    check_eq("ign_am_reset", bus.am_reset, 0);
    @(posedge clk);
    #1;
    send_beat(8'h44, 1'b0);
    send_beat(8'h55, 1'b1);
    wait_done(50);

    // Reset mid-STREAM with two queued entries.
    mode = 2;
    bus.rpt_ready = 1'b0;
    start_trace();
    send_beat(8'h61, 1'b0);
    send_beat(8'h62, 1'b0);
    repeat (4) @(posedge clk);
    #1;
    @(negedge clk);
    check_eq("pre_rst_rpt_valid", bus.rpt_valid, 1);
    base = done_cnt;
    @(posedge clk);
    #1;
    apply_reset(1);
    check_eq("rst_no_done", done_cnt, base);
    repeat (5) @(posedge clk);
    #1;
    check_eq("rst_no_done_later", done_cnt, base);
    check_eq("rst_busy_later", bus.busy, 0);
    bus.rpt_ready = 1'b1;
    mode = 1;
    start_trace();
    trace_q = '{8'h01, 8'h20, 8'h02};
    send_trace();
    wait_done(50);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
